// File: rtl/rv32im_mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One access in flight; LSU wins ties unless IF has been passed over too often.
module rv32im_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_LSU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [3:0]            lsu_be_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_LSU} owner_e;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            be;
  } mem_req_t;

  state_e          state;
  owner_e          owner;
  mem_req_t        req_q;
  logic [SW-1:0]   lsu_streak;
  logic [CW-1:0]   to_cnt;

  logic            idle;
  logic            grant_lsu;
  logic            grant_if;
  logic            timeout;
  logic            resp_fire;
  logic            resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  assign idle    = (state == IDLE);
  assign busy_o  = !idle;
  assign timeout = (to_cnt == TO_LAST);

  // Grants are combinational so the requester sees acceptance in its request
  // cycle; gated by reset so every output reads 0 while rst_ni is low.
  assign grant_lsu = rst_ni && idle && lsu_req_i &&
                     !(if_req_i && (lsu_streak == STREAK_MAX));
  assign grant_if  = rst_ni && idle && if_req_i && !grant_lsu;
  assign lsu_gnt_o = grant_lsu;
  assign if_gnt_o  = grant_if;

  assign mem_req_o   = req_q.req;
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_be_o    = req_q.be;

  // Progress (grant in REQ, rvalid in WAIT) beats the timeout in the same cycle.
  always_comb begin
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    if (state == REQ) begin
      if (!mem_gnt_i && timeout) begin
        resp_fire = 1'b1;
        resp_err  = 1'b1;
      end
    end else if (state == WAIT) begin
      if (mem_rvalid_i) begin
        resp_fire = 1'b1;
        resp_data = req_q.we ? '0 : mem_rdata_i;
      end else if (timeout) begin
        resp_fire = 1'b1;
        resp_err  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      req_q      <= '0;
      lsu_streak <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            state       <= REQ;
            owner       <= OWN_LSU;
            to_cnt      <= '0;
            req_q.req   <= 1'b1;
            req_q.we    <= lsu_we_i;
            req_q.addr  <= lsu_addr_i;
            req_q.wdata <= lsu_wdata_i;
            req_q.be    <= lsu_be_i;
            if (!if_req_i)
              lsu_streak <= '0;
            else if (lsu_streak != STREAK_MAX)
              lsu_streak <= lsu_streak + 1'b1;
          end else if (grant_if) begin
            state       <= REQ;
            owner       <= OWN_IF;
            to_cnt      <= '0;
            req_q.req   <= 1'b1;
            req_q.we    <= 1'b0;
            req_q.addr  <= if_addr_i;
            req_q.wdata <= '0;
            req_q.be    <= 4'hF;
            lsu_streak  <= '0;
          end
        end
        REQ: begin
          if (!timeout) to_cnt <= to_cnt + 1'b1;
          if (mem_gnt_i) begin
            req_q.req <= 1'b0;
            state     <= WAIT;
          end else if (resp_fire) begin
            req_q.req <= 1'b0;
            state     <= RESP;
          end
        end
        WAIT: begin
          if (!timeout) to_cnt <= to_cnt + 1'b1;
          if (resp_fire) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response registers hold their last value until the owner's next response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_rvalid_o  <= 1'b0;
      if_rdata_o   <= '0;
      if_err_o     <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= '0;
      lsu_err_o    <= 1'b0;
    end else begin
      if_rvalid_o  <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      if (resp_fire) begin
        if (owner == OWN_LSU) begin
          lsu_rvalid_o <= 1'b1;
          lsu_rdata_o  <= resp_data;
          lsu_err_o    <= resp_err;
        end else begin
          if_rvalid_o  <= 1'b1;
          if_rdata_o   <= resp_data;
          if_err_o     <= resp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
// Random and directed traffic against a transaction-level model of the arbiter.
module tb_rv32im_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4, TO = 64, NEVER = 1000;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [AW-1:0] lsu_addr_i;
  logic [DW-1:0] lsu_wdata_i, lsu_rdata_o;
  logic [3:0] lsu_be_i;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_be_o;

  rv32im_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LSU_STREAK(MAXS),
                       .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_be_i(lsu_be_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Requester / memory model state
  bit if_pend, lsu_pend, lsu_w;
  logic [AW-1:0] if_a, lsu_a;
  logic [DW-1:0] lsu_d;
  logic [3:0] lsu_b;
  int req_pct = 0;
  int lsu_run = 0;           // LSU grants in a row taken while IF was waiting
  logic [DW-1:0] exp_if_rd = '0, exp_lsu_rd = '0;
  logic exp_if_er = 1'b0, exp_lsu_er = 1'b0;
  int obs_run = 0, obs_max_run = 0;

  task automatic new_reqs();
    if (!if_pend && $urandom_range(99) < req_pct) begin
      if_pend = 1; if_a = $urandom & 32'hFFFF_FFFC;
    end
    if (!lsu_pend && $urandom_range(99) < req_pct) begin
      lsu_pend = 1; lsu_a = $urandom; lsu_w = $urandom_range(1);
      lsu_d = $urandom; lsu_b = 4'($urandom);
    end
    if_req_i    = if_pend;
    if_addr_i   = if_pend ? if_a : $urandom;
    lsu_req_i   = lsu_pend;
    lsu_addr_i  = lsu_pend ? lsu_a : $urandom;
    lsu_we_i    = lsu_pend ? lsu_w : 1'($urandom);
    lsu_wdata_i = lsu_pend ? lsu_d : $urandom;
    lsu_be_i    = lsu_pend ? lsu_b : 4'($urandom);
  endtask

  task automatic chk_hold();
    chk("if_rdata_hold", if_rdata_o, exp_if_rd);
    chk("if_err_hold", if_err_o, exp_if_er);
    chk("lsu_rdata_hold", lsu_rdata_o, exp_lsu_rd);
    chk("lsu_err_hold", lsu_err_o, exp_lsu_er);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {if_gnt_o, if_rvalid_o, if_err_o, lsu_gnt_o, lsu_rvalid_o, lsu_err_o,
                        mem_req_o, mem_we_o, mem_be_o, busy_o}, 64'd0);
    chk({tag, "_rdata"}, {if_rdata_o, lsu_rdata_o}, 64'd0);
    chk({tag, "_mem"}, {mem_addr_o, mem_wdata_o}, 64'd0);
  endtask

  // One full transaction: IDLE arbitration, REQ for gd cycles, WAIT rd cycles, RESP.
  // Entered and left just after a rising edge.
  task automatic run_txn(input int gd, input int rd, input logic [DW-1:0] md);
    bit g_if, g_lsu, got, own_lsu, in_wait, done, gnt_now, rv_now;
    logic [AW-1:0] t_a; logic t_we; logic [DW-1:0] t_wd, rsp_d; logic [3:0] t_be;
    logic rsp_e;
    int wc;
    got = 0; own_lsu = 0; t_a = '0; t_we = 0; t_wd = '0; t_be = '0; rsp_d = '0; rsp_e = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      new_reqs();
      mem_gnt_i = $urandom_range(1); mem_rvalid_i = $urandom_range(1); mem_rdata_i = $urandom;
      g_lsu = lsu_pend && !(if_pend && lsu_run == MAXS);
      g_if  = if_pend && !g_lsu;
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      chk("if_gnt", if_gnt_o, g_if);
      chk("lsu_gnt", lsu_gnt_o, g_lsu);
      chk("idle_mem_req", mem_req_o, 0);
      chk("idle_rvalid", {if_rvalid_o, lsu_rvalid_o}, 0);
      chk_hold();
      if (lsu_gnt_o) begin obs_run++; if (obs_run > obs_max_run) obs_max_run = obs_run; end
      if (if_gnt_o) obs_run = 0;
      if (g_lsu) begin
        lsu_run = if_pend ? lsu_run + 1 : 0;
        own_lsu = 1; t_a = lsu_a; t_we = lsu_w; t_wd = lsu_d; t_be = lsu_b;
        lsu_pend = 0; got = 1;
      end else if (g_if) begin
        lsu_run = 0;
        own_lsu = 0; t_a = if_a; t_we = 0; t_wd = '0; t_be = 4'hF;
        if_pend = 0; got = 1;
      end
      @(posedge clk_i); #1;
    end
    if (!got) begin chk("grant_seen", 0, 1); return; end

    in_wait = 0; done = 0; wc = 0;
    for (int c = 0; c < TO + 8 && !done; c++) begin
      new_reqs();
      mem_rdata_i = $urandom;
      if (!in_wait) begin
        gnt_now = (c == gd); rv_now = $urandom_range(1);
      end else begin
        gnt_now = 0; rv_now = (wc == rd);
        if (rv_now) mem_rdata_i = md;
      end
      mem_gnt_i = gnt_now; mem_rvalid_i = rv_now;
      @(negedge clk_i);
      chk("busy", busy_o, 1);
      chk("busy_gnt", {if_gnt_o, lsu_gnt_o}, 0);
      chk("busy_rvalid", {if_rvalid_o, lsu_rvalid_o}, 0);
      chk_hold();
      if (!in_wait) begin
        chk("req_mem_req", mem_req_o, 1);
        chk("req_addr", mem_addr_o, t_a);
        chk("req_we", mem_we_o, t_we);
        chk("req_be", mem_be_o, t_be);
        if (t_we) chk("req_wdata", mem_wdata_o, t_wd);
      end else begin
        chk("wait_mem_req", mem_req_o, 0);
      end
      @(posedge clk_i); #1;
      if (!in_wait && gnt_now) begin in_wait = 1; wc = 0; end
      else if (in_wait && rv_now) begin done = 1; rsp_e = 0; rsp_d = t_we ? '0 : md; end
      else begin
        if (c >= TO - 1) begin done = 1; rsp_e = 1; rsp_d = '0; end
        if (in_wait) wc++;
      end
    end
    if (!done) begin chk("resp_seen", 0, 1); return; end

    new_reqs();
    mem_gnt_i = 0; mem_rvalid_i = $urandom_range(1); mem_rdata_i = $urandom;
    if (own_lsu) begin exp_lsu_rd = rsp_d; exp_lsu_er = rsp_e; end
    else begin exp_if_rd = rsp_d; exp_if_er = rsp_e; end
    @(negedge clk_i);
    chk("resp_busy", busy_o, 1);
    chk("resp_gnt", {if_gnt_o, lsu_gnt_o}, 0);
    chk("resp_mem_req", mem_req_o, 0);
    chk("if_rvalid", if_rvalid_o, !own_lsu);
    chk("lsu_rvalid", lsu_rvalid_o, own_lsu);
    chk_hold();
    @(posedge clk_i); #1;
  endtask

  task automatic model_reset();
    if_pend = 0; lsu_pend = 0; lsu_run = 0; obs_run = 0;
    exp_if_rd = '0; exp_lsu_rd = '0; exp_if_er = 0; exp_lsu_er = 0;
  endtask

  task automatic reset_in_wait();
    req_pct = 0; if_pend = 0;
    lsu_pend = 1; lsu_a = 32'h300; lsu_w = 0; lsu_d = '0; lsu_b = 4'hF;
    new_reqs(); mem_gnt_i = 0; mem_rvalid_i = 0;
    @(negedge clk_i);
    chk("rstw_gnt", lsu_gnt_o, 1);
    lsu_pend = 0; lsu_run = 0;
    @(posedge clk_i); #1; new_reqs(); mem_gnt_i = 1;
    @(posedge clk_i); #1; new_reqs(); mem_gnt_i = 0;
    chk("rstw_busy", busy_o, 1);
    if_req_i = 1; lsu_req_i = 1;
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("rstw_async");
    @(posedge clk_i); #1; mem_rvalid_i = 1; mem_rdata_i = $urandom;
    @(negedge clk_i);
    chk_all_zero("rstw_hold");
    if_req_i = 0; lsu_req_i = 0; rst_ni = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1; mem_rvalid_i = 1; mem_rdata_i = $urandom;
      @(negedge clk_i);
      chk("post_rst_rvalid", {if_rvalid_o, lsu_rvalid_o}, 0);
      chk("post_rst_busy", busy_o, 0);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    if_req_i = 1; lsu_req_i = 1; if_addr_i = 32'h40; lsu_addr_i = 32'h80;
    lsu_we_i = 1; lsu_wdata_i = '1; lsu_be_i = 4'hF;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = '1;
    @(negedge clk_i);
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1; if_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    @(posedge clk_i); #1;

    // IF read at 0x100, immediate grant, data one cycle later
    if_pend = 1; if_a = 32'h100;
    run_txn(0, 0, 32'hDEADBEEF);
    chk("if_read_data", if_rdata_o, 32'hDEADBEEF);

    // LSU partial write with delayed memory grant
    lsu_pend = 1; lsu_a = 32'h200; lsu_w = 1; lsu_d = 32'h12345678; lsu_b = 4'b0011;
    run_txn(3, 1, 32'hCAFEF00D);
    chk("lsu_write_rdata", lsu_rdata_o, 32'h0);

    // Simultaneous requests with no history: LSU first, then IF
    if_pend = 1; if_a = 32'h400;
    lsu_pend = 1; lsu_a = 32'h500; lsu_w = 0; lsu_d = '0; lsu_b = 4'hF;
    run_txn(0, 0, 32'h0BAD_F00D);
    chk("tie_lsu_first", lsu_rdata_o, 32'h0BAD_F00D);
    run_txn(1, 0, 32'h1234_0000);
    chk("tie_if_next", if_rdata_o, 32'h1234_0000);

    // Both requesters always busy: starvation bound on IF
    req_pct = 100; obs_run = 0; obs_max_run = 0;
    for (int i = 0; i < 20; i++) run_txn($urandom_range(1), $urandom_range(1), $urandom);
    chk("streak_max_reached", obs_max_run, MAXS);

    // Timeouts: stuck in WAIT, then stuck in REQ
    req_pct = 0; if_pend = 0; lsu_pend = 1; lsu_a = 32'h600; lsu_w = 0; lsu_b = 4'hF;
    run_txn(0, NEVER, 32'h0);
    chk("to_wait_err", lsu_err_o, 1);
    if_pend = 1; if_a = 32'h700;
    run_txn(NEVER, 0, 32'h0);
    chk("to_req_err", if_err_o, 1);

    // Random mix
    req_pct = 40;
    for (int i = 0; i < 60; i++)
      run_txn(($urandom_range(19) == 0) ? NEVER : $urandom_range(3), $urandom_range(3), $urandom);

    // Reset during WAIT, then a normal first access
    reset_in_wait();
    if_pend = 1; if_a = 32'h800;
    run_txn(0, 0, 32'h5555AAAA);
    chk("post_rst_first", if_rdata_o, 32'h5555AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32im_mem_arbiter.md
Name: rv32im_mem_arbiter

Overview:
- Shares one memory port between instruction fetch (IF, read-only) and the EXU load/store path (LSU, read/write with byte mask).
- Sits between the core's fetch/LSU interfaces and the single memory bus.
- One outstanding transaction at a time. LSU has priority; an anti-starvation counter bounds IF stall. A timeout aborts a hung access with an error response.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IF is waiting before IF is forced.
- TIMEOUT_CYCLES, 64, cycles spent in REQ+WAIT before the access is aborted.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch accepted (one-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (one-cycle pulse)
- if_rdata_o  out  DATA_WIDTH  fetch data
- if_err_o  out  1  fetch response is an error; qualified by if_rvalid_o
- lsu_req_i  in  1  LSU request, held until lsu_gnt_o
- lsu_we_i  in  1  1 = write
- lsu_addr_i  in  ADDR_WIDTH  LSU address
- lsu_wdata_i  in  DATA_WIDTH  write data
- lsu_be_i  in  4  byte enables
- lsu_gnt_o  out  1  LSU accepted (one-cycle pulse)
- lsu_rvalid_o  out  1  LSU response valid (one-cycle pulse)
- lsu_rdata_o  out  DATA_WIDTH  load data
- lsu_err_o  out  1  LSU response is an error; qualified by lsu_rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_be_o  out  4  memory byte enables
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response/ack
- mem_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - Owner = IF.
  - lsu_streak = 0.
  - Timeout counter = 0.
- Reset mid-transaction drops everything immediately. No response is generated.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Arbitration is combinational on the req inputs.
  - If lsu_req_i and not (if_req_i and lsu_streak == MAX_LSU_STREAK), grant LSU. Otherwise, if if_req_i, grant IF.
  - The granted gnt_o is asserted in this cycle. At the clock edge: latch owner, addr, wdata, be, we (IF: we=0, be=4'hF); clear timeout counter; go to REQ.
- lsu_streak:
  - On an LSU grant while if_req_i=1: increment, saturating at MAX_LSU_STREAK.
  - On an IF grant: clear.
  - On an LSU grant while if_req_i=0: clear.
- REQ:
  - mem_req_o=1 with the latched fields driven on the mem_* outputs.
  - On mem_gnt_i: mem_req_o drops at the next edge; go to WAIT.
  - mem_* fields are stable for the whole time mem_req_o=1.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i: register mem_rdata_i (0 for writes) and err=0; go to RESP.
  - mem_rvalid_i is only honoured in WAIT. It is ignored elsewhere, including in the mem_gnt_i cycle.
- RESP:
  - The owner's rvalid_o=1 for exactly one cycle, with rdata_o/err_o valid; the other requester's rvalid_o stays 0.
  - Go to IDLE. A new grant is possible on the following cycle.
- Timeout:
  - The counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without progress: force mem_req_o=0, go to RESP with err=1 and rdata=0.
  - Late mem_rvalid_i for an aborted access arriving in IDLE/REQ is ignored.
- Latency: request seen in cycle 0 (gnt_o), mem_req_o from cycle 1. mem_gnt_i in cycle n gives WAIT from n+1. mem_rvalid_i in cycle k gives rvalid_o in cycle k+1. Minimum request-to-response is 3 cycles.
- Requester gnt_o never asserts outside IDLE. Requests arriving while busy are held by the requester.
- rdata_o/err_o hold their value after the RESP pulse until the next RESP for that requester.

Test Plan:
- Single IF read, addr 0x100, mem_gnt_i immediate, rvalid 1 cycle later with 0xDEADBEEF -> if_gnt_o cycle 0, mem_req_o cycle 1, if_rvalid_o cycle 3, if_rdata_o=0xDEADBEEF, if_err_o=0.
- LSU write, addr 0x200, wdata 0x12345678, be 4'b0011, mem_gnt_i delayed 3 cycles -> mem_* fields stable through all REQ cycles, lsu_rvalid_o one cycle after mem_rvalid_i, lsu_rdata_o=0.
- IF and LSU continuously requesting, MAX_LSU_STREAK=4 -> grant order LSU,LSU,LSU,LSU,IF,LSU..., never more than 4 LSU grants between IF grants.
- Simultaneous requests in IDLE with lsu_streak=0 -> LSU granted, if_gnt_o=0, and IF is granted on the next IDLE.
- mem_gnt_i given, mem_rvalid_i never arrives, TIMEOUT_CYCLES=64 -> owner rvalid_o with err_o=1, rdata_o=0, 64 cycles after entering REQ. A late mem_rvalid_i is then ignored.
- rst_ni asserted low during WAIT -> all outputs 0 asynchronously. No rvalid_o after release. The first request after reset is granted normally.
